// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: RV32I funct3 encodings, FSM states, error codes.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        NONE       = 2'd0,
        MISALIGNED = 2'd1,
        TIMEOUT    = 2'd2
    } lsu_err_e;

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
        if (is_store)
            return funct3 inside {F3_SB, F3_SH, F3_SW};
        return funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: enables, store-data replication, alignment check and load extraction.
// Purely combinational; no state, no backpressure.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        bad,
    output logic [31:0] load_data
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        case (addr_lo)
            2'd0:    rbyte = rdata[7:0];
            2'd1:    rbyte = rdata[15:8];
            2'd2:    rbyte = rdata[23:16];
            default: rbyte = rdata[31:24];
        endcase
        rhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // bad covers both misalignment and encodings that are neither a legal load nor store
    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        bad       = !funct3_legal(is_store, funct3);
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                if (addr_lo[0])
                    bad = 1'b1;
            end
            2'b10: begin
                be = 4'b1111;
                if (addr_lo != 2'b00)
                    bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        case (funct3)
            F3_LB:   load_data = {{24{rbyte[7]}}, rbyte};
            F3_LBU:  load_data = {24'd0, rbyte};
            F3_LH:   load_data = {{16{rhalf[15]}}, rhalf};
            F3_LHU:  load_data = {16'd0, rhalf};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one access at a time from execute to data memory and back to writeback.
// Best case 2 cycles accept-to-result; mem_req held until mem_gnt, out_valid held until out_ready.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic [1:0]  out_err
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state;
    logic [7:0]  cnt;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;

    logic        sel_in;
    logic        a_store;
    logic [2:0]  a_funct3;
    logic [1:0]  a_lo;
    logic [3:0]  a_be;
    logic [31:0] a_wdata;
    logic        a_bad;
    logic [31:0] a_load;
    logic        timed_out;

    // One aligner serves both ends: incoming fields while idle, captured fields while in flight
    assign sel_in   = (state == IDLE);
    assign a_store  = sel_in ? in_is_store : is_store_q;
    assign a_funct3 = sel_in ? in_funct3 : funct3_q;
    assign a_lo     = sel_in ? in_addr[1:0] : addr_lo_q;

    assign timed_out = (cnt == CNT_LAST);

    lsu_align u_align (
        .is_store  (a_store),
        .funct3    (a_funct3),
        .addr_lo   (a_lo),
        .wdata     (in_wdata),
        .rdata     (mem_rdata),
        .be        (a_be),
        .wdata_rep (a_wdata),
        .bad       (a_bad),
        .load_data (a_load)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            is_store_q <= 1'b0;
            funct3_q   <= 3'd0;
            addr_lo_q  <= 2'd0;
            in_ready   <= 1'b1;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= 4'd0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            out_valid  <= 1'b0;
            out_rdata  <= 32'd0;
            out_err    <= NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        is_store_q <= in_is_store;
                        funct3_q   <= in_funct3;
                        addr_lo_q  <= in_addr[1:0];
                        in_ready   <= 1'b0;
                        cnt        <= 8'd0;
                        if (a_bad) begin
                            state     <= RESP;
                            out_valid <= 1'b1;
                            out_err   <= MISALIGNED;
                            out_rdata <= 32'd0;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= in_is_store;
                            mem_be    <= a_be;
                            mem_addr  <= {in_addr[31:2], 2'b00};
                            mem_wdata <= a_wdata;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt && mem_rvalid) begin
                        mem_req   <= 1'b0;
                        state     <= RESP;
                        out_valid <= 1'b1;
                        out_err   <= NONE;
                        out_rdata <= is_store_q ? 32'd0 : a_load;
                    end else if (timed_out) begin
                        // a grant in the last cycle is abandoned; its response is ignored later
                        mem_req   <= 1'b0;
                        state     <= RESP;
                        out_valid <= 1'b1;
                        out_err   <= TIMEOUT;
                        out_rdata <= 32'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (mem_gnt) begin
                            mem_req <= 1'b0;
                            state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state     <= RESP;
                        out_valid <= 1'b1;
                        out_err   <= NONE;
                        out_rdata <= is_store_q ? 32'd0 : a_load;
                    end else if (timed_out) begin
                        state     <= RESP;
                        out_valid <= 1'b1;
                        out_err   <= TIMEOUT;
                        out_rdata <= 32'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: main instance with default timeout, second instance with an 8-cycle timeout.
module tb_lsu;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, in_is_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_wdata;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        out_valid, out_ready;
    logic [31:0] out_rdata;
    logic [1:0]  out_err;

    logic        t_in_valid, t_in_ready, t_in_is_store;
    logic [2:0]  t_in_funct3;
    logic [31:0] t_in_addr, t_in_wdata;
    logic        t_mem_req, t_mem_gnt, t_mem_we, t_mem_rvalid;
    logic [3:0]  t_mem_be;
    logic [31:0] t_mem_addr, t_mem_wdata, t_mem_rdata;
    logic        t_out_valid, t_out_ready;
    logic [31:0] t_out_rdata;
    logic [1:0]  t_out_err;

    int vecs = 0;
    int errs = 0;

    lsu dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err)
    );

    lsu #(.TIMEOUT_CYCLES(8)) dut_t (
        .clk(clk), .rst_n(rst_n),
        .in_valid(t_in_valid), .in_ready(t_in_ready), .in_is_store(t_in_is_store),
        .in_funct3(t_in_funct3), .in_addr(t_in_addr), .in_wdata(t_in_wdata),
        .mem_req(t_mem_req), .mem_gnt(t_mem_gnt), .mem_we(t_mem_we), .mem_be(t_mem_be),
        .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata), .mem_rvalid(t_mem_rvalid), .mem_rdata(t_mem_rdata),
        .out_valid(t_out_valid), .out_ready(t_out_ready), .out_rdata(t_out_rdata), .out_err(t_out_err)
    );

    typedef struct packed {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [3:0]  be;
        logic [31:0] ma;
        logic [31:0] mwd;
        logic [31:0] ord;
    } acc_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single access with gnt+rvalid in the first request cycle; returns what was observed.
    task automatic run_simple(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd,
                              output logic [3:0] be, output logic [31:0] ma, output logic [31:0] mwd,
                              output logic req, output logic we, output logic [31:0] ord,
                              output logic [1:0] oerr, output logic ov);
        in_valid = 1'b1; in_is_store = st; in_funct3 = f3; in_addr = a; in_wdata = wd;
        tick();
        in_valid = 1'b0;
        be = mem_be; ma = mem_addr; mwd = mem_wdata; req = mem_req; we = mem_we;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = rd; out_ready = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        ord = out_rdata; oerr = out_err; ov = out_valid;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [105:0] exp_r;
        exp_r = {1'b1, 105'd0};
        rst_n = 1'b0;
        tick(); tick();
        if ({in_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata, out_valid, out_rdata, out_err} !== exp_r) begin
            $display("FAIL reset_outputs: got %h expected %h",
                {in_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata, out_valid, out_rdata, out_err}, exp_r);
            errs++;
        end
        vecs++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sb_timing();
        in_valid = 1'b1; in_is_store = 1'b1; in_funct3 = F3_SB; in_addr = 32'h103; in_wdata = 32'hA5;
        if (in_ready !== 1'b1) begin $display("FAIL sb_accept_ready: got %b expected 1", in_ready); errs++; end
        vecs++;
        tick();
        in_valid = 1'b0;
        if ({in_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b0, 1'b1, 1'b1, 4'b1000, 32'h100, 32'hA5A5_A5A5}) begin
            $display("FAIL sb_request: got rdy=%b req=%b we=%b be=%b addr=%h wd=%h expected 0 1 1 1000 00000100 a5a5a5a5",
                in_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
            errs++;
        end
        vecs++;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; out_ready = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        if ({mem_req, out_valid, out_err, out_rdata} !== {1'b0, 1'b1, 2'd0, 32'd0}) begin
            $display("FAIL sb_result: got req=%b ov=%b err=%0d rd=%h expected 0 1 0 00000000",
                mem_req, out_valid, out_err, out_rdata);
            errs++;
        end
        vecs++;
        tick();
        out_ready = 1'b0;
        if ({in_ready, out_valid} !== 2'b10) begin
            $display("FAIL sb_return_idle: got rdy=%b ov=%b expected 1 0", in_ready, out_valid);
            errs++;
        end
        vecs++;
    endtask

    task automatic test_lanes();
        acc_t tbl [9];
        logic [3:0] be; logic [31:0] ma, mwd, ord; logic req, we, ov; logic [1:0] oerr;
        tbl[0] = '{1'b0, F3_LH,  32'h22, 32'h0,         32'h8001_1234, 4'b1100, 32'h20, 32'h0,         32'hFFFF_8001};
        tbl[1] = '{1'b0, F3_LHU, 32'h22, 32'h0,         32'h8001_1234, 4'b1100, 32'h20, 32'h0,         32'h0000_8001};
        tbl[2] = '{1'b0, F3_LB,  32'h20, 32'h0,         32'h1234_5680, 4'b0001, 32'h20, 32'h0,         32'hFFFF_FF80};
        tbl[3] = '{1'b0, F3_LBU, 32'h21, 32'h0,         32'h0000_F100, 4'b0010, 32'h20, 32'h0,         32'h0000_00F1};
        tbl[4] = '{1'b0, F3_LW,  32'h44, 32'h0,         32'hDEAD_BEEF, 4'b1111, 32'h44, 32'h0,         32'hDEAD_BEEF};
        tbl[5] = '{1'b1, F3_SH,  32'h12, 32'h1234_ABCD, 32'hFFFF_FFFF, 4'b1100, 32'h10, 32'hABCD_ABCD, 32'h0};
        tbl[6] = '{1'b1, F3_SW,  32'h48, 32'hCAFE_F00D, 32'hFFFF_FFFF, 4'b1111, 32'h48, 32'hCAFE_F00D, 32'h0};
        tbl[7] = '{1'b0, F3_LH,  32'h2C, 32'h0,         32'hFFFF_7FFF, 4'b0011, 32'h2C, 32'h0,         32'h0000_7FFF};
        tbl[8] = '{1'b0, F3_LB,  32'h23, 32'h0,         32'h7F80_8080, 4'b1000, 32'h20, 32'h0,         32'h0000_007F};
        for (int i = 0; i < 9; i++) begin
            run_simple(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].rd, be, ma, mwd, req, we, ord, oerr, ov);
            if ({req, we, be, ma, ov, oerr, ord} !== {1'b1, tbl[i].st, tbl[i].be, tbl[i].ma, 1'b1, 2'd0, tbl[i].ord}) begin
                $display("FAIL lane_access[%0d]: got req=%b we=%b be=%b addr=%h ov=%b err=%0d rd=%h expected 1 %b %b %h 1 0 %h",
                    i, req, we, be, ma, ov, oerr, ord, tbl[i].st, tbl[i].be, tbl[i].ma, tbl[i].ord);
                errs++;
            end
            vecs++;
            if (tbl[i].st) begin
                if (mwd !== tbl[i].mwd) begin
                    $display("FAIL lane_wdata[%0d]: got %h expected %h", i, mwd, tbl[i].mwd);
                    errs++;
                end
                vecs++;
            end
        end
    endtask

    task automatic test_misaligned();
        logic        st [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3 [5] = '{F3_LW, F3_LH, F3_SW, 3'b011, 3'b100};
        logic [31:0] ad [5] = '{32'h41, 32'h23, 32'h102, 32'h40, 32'h40};
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_is_store = st[i]; in_funct3 = f3[i]; in_addr = ad[i]; in_wdata = 32'h5555_5555;
            out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            if ({mem_req, out_valid, out_err, out_rdata} !== {1'b0, 1'b1, 2'd1, 32'd0}) begin
                $display("FAIL misaligned[%0d]: got req=%b ov=%b err=%0d rd=%h expected 0 1 1 00000000",
                    i, mem_req, out_valid, out_err, out_rdata);
                errs++;
            end
            vecs++;
            tick();
            out_ready = 1'b0;
            if ({mem_req, in_ready, out_valid} !== 3'b010) begin
                $display("FAIL misaligned_idle[%0d]: got req=%b rdy=%b ov=%b expected 0 1 0", i, mem_req, in_ready, out_valid);
                errs++;
            end
            vecs++;
        end
    endtask

    task automatic test_stall();
        in_valid = 1'b1; in_is_store = 1'b0; in_funct3 = F3_LHU; in_addr = 32'h36; in_wdata = 32'h0;
        mem_rdata = 32'hFFFF_FFFF; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c == 6) mem_gnt = 1'b1;
            if ({mem_req, mem_addr, mem_be} !== {1'b1, 32'h34, 4'b1100}) begin
                $display("FAIL stall_req_stable[c%0d]: got req=%b addr=%h be=%b expected 1 00000034 1100",
                    c, mem_req, mem_addr, mem_be);
                errs++;
            end
            vecs++;
            tick();
        end
        mem_gnt = 1'b0;
        if ({mem_req, out_valid} !== 2'b00) begin
            $display("FAIL stall_wait: got req=%b ov=%b expected 0 0", mem_req, out_valid);
            errs++;
        end
        vecs++;
        tick(); tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h5678_9ABC;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) out_ready = 1'b1;
            if ({out_valid, out_err, out_rdata, in_ready} !== {1'b1, 2'd0, 32'h0000_5678, 1'b0}) begin
                $display("FAIL stall_out_held[%0d]: got ov=%b err=%0d rd=%h rdy=%b expected 1 0 00005678 0",
                    c, out_valid, out_err, out_rdata, in_ready);
                errs++;
            end
            vecs++;
            tick();
        end
        out_ready = 1'b0;
        if ({out_valid, in_ready} !== 2'b01) begin
            $display("FAIL stall_release: got ov=%b rdy=%b expected 0 1", out_valid, in_ready);
            errs++;
        end
        vecs++;
    endtask

    task automatic test_timeout();
        int n;
        t_in_valid = 1'b1; t_in_is_store = 1'b0; t_in_funct3 = F3_LW; t_in_addr = 32'h80;
        tick();
        t_in_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && t_mem_req === 1'b1; i++) begin
            n++;
            tick();
        end
        if (n != 8) begin $display("FAIL timeout_req_cycles: got %0d expected 8", n); errs++; end
        vecs++;
        if ({t_mem_req, t_out_valid, t_out_err, t_out_rdata} !== {1'b0, 1'b1, 2'd2, 32'd0}) begin
            $display("FAIL timeout_result: got req=%b ov=%b err=%0d rd=%h expected 0 1 2 00000000",
                t_mem_req, t_out_valid, t_out_err, t_out_rdata);
            errs++;
        end
        vecs++;
        t_out_ready = 1'b1;
        tick();
        t_out_ready = 1'b0;
        t_mem_rvalid = 1'b1; t_mem_rdata = 32'hBAD0_BAD0;
        tick();
        t_mem_rvalid = 1'b0;
        if ({t_out_valid, t_in_ready, t_mem_req} !== 3'b010) begin
            $display("FAIL timeout_late_rvalid: got ov=%b rdy=%b req=%b expected 0 1 0", t_out_valid, t_in_ready, t_mem_req);
            errs++;
        end
        vecs++;
        t_in_valid = 1'b1; t_in_funct3 = F3_LW; t_in_addr = 32'h84;
        tick();
        t_in_valid = 1'b0;
        t_mem_gnt = 1'b1;
        tick();
        t_mem_gnt = 1'b0;
        t_mem_rvalid = 1'b1; t_mem_rdata = 32'h1122_3344; t_out_ready = 1'b1;
        tick();
        t_mem_rvalid = 1'b0;
        if ({t_out_valid, t_out_err, t_out_rdata} !== {1'b1, 2'd0, 32'h1122_3344}) begin
            $display("FAIL timeout_next_lw: got ov=%b err=%0d rd=%h expected 1 0 11223344",
                t_out_valid, t_out_err, t_out_rdata);
            errs++;
        end
        vecs++;
        tick();
        t_out_ready = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        logic [105:0] exp_r;
        exp_r = {1'b1, 105'd0};
        in_valid = 1'b1; in_is_store = 1'b1; in_funct3 = F3_SW; in_addr = 32'h200; in_wdata = 32'h7777_7777;
        tick();
        in_valid = 1'b0;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        rst_n = 1'b0;
        tick();
        if ({in_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata, out_valid, out_rdata, out_err} !== exp_r) begin
            $display("FAIL reset_in_wait: got %h expected %h",
                {in_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata, out_valid, out_rdata, out_err}, exp_r);
            errs++;
        end
        vecs++;
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        if ({out_valid, in_ready} !== 2'b01) begin
            $display("FAIL reset_abandon: got ov=%b rdy=%b expected 0 1", out_valid, in_ready);
            errs++;
        end
        vecs++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] be; logic [31:0] ma, mwd, ord; logic req, we, ov; logic [1:0] oerr;
        run_simple(1'b0, F3_LBU, 32'h302, 32'h0, 32'h00AB_0000, be, ma, mwd, req, we, ord, oerr, ov);
        run_simple(1'b0, F3_LH, 32'h300, 32'h0, 32'h0000_8ACE, be, ma, mwd, req, we, ord, oerr, ov);
        if ({be, ma, ord, oerr, ov} !== {4'b0011, 32'h300, 32'hFFFF_8ACE, 2'd0, 1'b1}) begin
            $display("FAIL back_to_back: got be=%b addr=%h rd=%h err=%0d ov=%b expected 0011 00000300 ffff8ace 0 1",
                be, ma, ord, oerr, ov);
            errs++;
        end
        vecs++;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_is_store = 1'b0; in_funct3 = 3'd0; in_addr = 32'd0; in_wdata = 32'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0; out_ready = 1'b0;
        t_in_valid = 1'b0; t_in_is_store = 1'b0; t_in_funct3 = 3'd0; t_in_addr = 32'd0; t_in_wdata = 32'd0;
        t_mem_gnt = 1'b0; t_mem_rvalid = 1'b0; t_mem_rdata = 32'd0; t_out_ready = 1'b0;

        test_reset();
        test_sb_timing();
        test_lanes();
        test_misaligned();
        test_stall();
        test_timeout();
        test_reset_in_wait();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
